// File: rtl/poly_note_player.sv
// Polyphonic saw-wave note player: per-voice IDLE/PLAY/DONE sequencers driven by beat
// ticks, phase accumulators advanced on sample ticks, and a registered signed mix.
module poly_note_player #(
   parameter int VOICES   = 4,
   parameter int K_W      = 20,
   parameter int ACC_W    = 22,
   parameter int DUR_W    = 6,
   parameter int SAMPLE_W = 16,
   localparam int VSEL_W  = (VOICES > 1) ? $clog2(VOICES) : 1,
   localparam int MIX_W   = SAMPLE_W + VSEL_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    play_enable,
   input  logic                    load_new_note,
   input  logic [VSEL_W-1:0]       voice_sel,
   input  logic [K_W-1:0]          k_to_load,
   input  logic [DUR_W-1:0]        duration_to_load,
   input  logic                    beat,
   input  logic                    sampling_pulse,
   output logic [VOICES-1:0]       note_done,
   output logic [VOICES-1:0]       voice_active,
   output logic signed [MIX_W-1:0] sample,
   output logic                    sample_ready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [SAMPLE_W-1:0] SAW_MSB = SAMPLE_W'(1) << (SAMPLE_W - 1);

   logic signed [SAMPLE_W-1:0] saw_term [VOICES];

   genvar gi;
   generate
      for (gi = 0; gi < VOICES; gi++) begin : g_voice
         logic [1:0]       state_reg, state_next;
         logic [K_W-1:0]   k_reg, k_next;
         logic [DUR_W-1:0] dur_reg, dur_next;
         logic [DUR_W-1:0] count_reg, count_next;
         logic [ACC_W-1:0] phase_reg, phase_next;
         logic [ACC_W-1:0] phase_upd;
         logic [ACC_W-1:0] mix_phase;
         logic [DUR_W:0]   count_inc;
         logic [SAMPLE_W-1:0] saw_raw;
         logic             load_hit;

         // Out-of-range voice_sel values never match any voice, so such loads are dropped.
         assign load_hit  = load_new_note && play_enable && (voice_sel == VSEL_W'(gi));
         assign phase_upd = sampling_pulse ? phase_reg + ACC_W'(k_reg) : phase_reg;
         assign count_inc = {1'b0, count_reg} + (DUR_W + 1)'(1);

         always_comb begin
            state_next = state_reg;
            k_next     = k_reg;
            dur_next   = dur_reg;
            count_next = count_reg;
            phase_next = phase_reg;
            if (!play_enable) begin
               state_next = ST_IDLE;
               count_next = '0;
               phase_next = '0;
            end else if (load_hit) begin
               state_next = ST_PLAY;
               k_next     = k_to_load;
               dur_next   = duration_to_load;
               count_next = '0;
               phase_next = '0;
            end else begin
               case (state_reg)
                  ST_PLAY: begin
                     phase_next = phase_upd;
                     // dur of 0 ends after the first beat, same as dur of 1.
                     if (beat) begin
                        if (count_inc >= {1'b0, dur_reg}) begin
                           state_next = ST_DONE;
                           count_next = '0;
                           phase_next = '0;
                        end else begin
                           count_next = count_inc[DUR_W-1:0];
                        end
                     end
                  end
                  default: begin
                     state_next = ST_IDLE;
                     count_next = '0;
                     phase_next = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg <= ST_IDLE;
               k_reg     <= '0;
               dur_reg   <= '0;
               count_reg <= '0;
               phase_reg <= '0;
            end else begin
               state_reg <= state_next;
               k_reg     <= k_next;
               dur_reg   <= dur_next;
               count_reg <= count_next;
               phase_reg <= phase_next;
            end
         end

         // A voice being (re)loaded this cycle contributes with phase 0, not advanced.
         assign mix_phase = load_hit ? '0 : phase_upd;
         assign saw_raw   = SAMPLE_W'(mix_phase >> (ACC_W - SAMPLE_W));
         assign saw_term[gi] = (state_reg == ST_PLAY) ? signed'(saw_raw ^ SAW_MSB) : '0;

         assign voice_active[gi] = (state_reg == ST_PLAY);
         assign note_done[gi]    = (state_reg == ST_DONE);
      end
   endgenerate

   logic signed [MIX_W-1:0] mix_sum;

   always_comb begin
      mix_sum = '0;
      for (int v = 0; v < VOICES; v++) begin
         mix_sum = mix_sum + MIX_W'(saw_term[v]);
      end
   end

   logic signed [MIX_W-1:0] sample_reg;
   logic                    sample_ready_reg;

   always_ff @(posedge clk) begin
      if (reset || !play_enable) begin
         sample_reg       <= '0;
         sample_ready_reg <= 1'b0;
      end else begin
         sample_ready_reg <= sampling_pulse;
         if (sampling_pulse) begin
            sample_reg <= mix_sum;
         end
      end
   end

   assign sample       = sample_reg;
   assign sample_ready = sample_ready_reg;

endmodule
